// File: rtl/gradient_accum_compressor_if.sv
// Gradient input stream and DRAM writeback stream for gradient_accum_compressor.
interface gradient_accum_compressor_if;
    logic               in_valid;
    logic        [31:0] in_addr;
    logic signed [15:0] in_grad;
    logic               in_ready;
    logic               dram_valid;
    logic        [31:0] dram_addr;
    logic signed [31:0] dram_value;
    logic               dram_ready;

    modport slave (
        input  in_valid, in_addr, in_grad, dram_ready,
        output in_ready, dram_valid, dram_addr, dram_value
    );

    modport master (
        output in_valid, in_addr, in_grad, dram_ready,
        input  in_ready, dram_valid, dram_addr, dram_value
    );
endinterface

// File: rtl/gradient_accum_compressor.sv
// Sparse gradient compressor: set-associative accumulate buffer, writeback FIFO, burst drain.
// Optional bandwidth counters are built when PERF_MON_EN is defined.
module gradient_accum_compressor #(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned NUM_WAYS    = 4,
    parameter logic [31:0] THRESHOLD   = 32'd50,
    parameter int unsigned MAX_UPDATES = 255,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned BURST_SIZE  = 16,
    parameter int unsigned IDLE_FLUSH  = 16,
    parameter int unsigned DATA_BYTES  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    gradient_accum_compressor_if.slave        bus,
    output logic                              debug_wb_direct,
    output logic                              debug_wb_accum_threshold,
    output logic                              debug_wb_max_updates,
    output logic                              debug_wb_eviction,
    output logic                              debug_hit,
    output logic                              debug_miss,
    output logic [$clog2(FIFO_DEPTH):0]       debug_fifo_count,
    output logic                              debug_burst_ready,
    output logic                              debug_fifo_full,
    output logic                              debug_draining,
    output logic [31:0]                       perf_raw_count,
    output logic [31:0]                       perf_out_count,
    output logic [31:0]                       perf_raw_bytes,
    output logic [31:0]                       perf_out_bytes
);
    localparam int unsigned SETS   = DEPTH / NUM_WAYS;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = 32 - IDX_W;
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_UPDATES + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned BCNT_W = $clog2(BURST_SIZE + 1);
    localparam int unsigned ICNT_W = $clog2(IDLE_FLUSH + 1);

    typedef enum logic [0:0] {StIdle, StBurst} drain_state_e;

    // Accumulate buffer
    logic               r_valid [SETS][NUM_WAYS];
    logic [TAG_W-1:0]   r_tag   [SETS][NUM_WAYS];
    logic signed [31:0] r_acc   [SETS][NUM_WAYS];
    logic [CNT_W-1:0]   r_cnt   [SETS][NUM_WAYS];
    logic [WAY_W-1:0]   r_rr    [SETS];

    // Writeback FIFO and drain control
    logic [31:0]        r_fifo_addr [FIFO_DEPTH];
    logic [31:0]        r_fifo_val  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [FCNT_W-1:0]  r_count;
    drain_state_e       r_state, w_state_next;
    logic [BCNT_W-1:0]  r_burst_cnt, w_burst_cnt_next;
    logic [ICNT_W-1:0]  r_idle_cnt;

    logic r_dbg_direct, r_dbg_thr, r_dbg_max, r_dbg_evict, r_dbg_hit, r_dbg_miss;

    logic               w_full, w_empty, w_accept, w_pop, w_dram_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit, w_has_free;
    logic [WAY_W-1:0]   w_hit_way, w_free_way, w_rr_cur, w_rr_next;
    logic signed [16:0] w_grad17;
    logic [16:0]        w_grad_mag;
    logic signed [31:0] w_grad32, w_acc_new;
    logic signed [32:0] w_acc33;
    logic [32:0]        w_acc_mag;
    logic [CNT_W-1:0]   w_cnt_new;
    logic               w_grad_big, w_acc_big, w_cnt_max;

    logic               w_push, w_wr_en, w_wr_valid, w_rr_inc;
    logic [31:0]        w_push_addr;
    logic signed [31:0] w_push_value, w_wr_acc;
    logic [WAY_W-1:0]   w_wr_way;
    logic [CNT_W-1:0]   w_wr_cnt;
    logic w_ev_direct, w_ev_thr, w_ev_max, w_ev_evict, w_ev_hit, w_ev_miss;

    assign w_full       = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign bus.in_ready = !w_full && !reset;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_dram_valid = (r_state == StBurst) && !w_empty;
    assign w_pop        = w_dram_valid && bus.dram_ready;

    assign w_idx = bus.in_addr[IDX_W-1:0];
    assign w_tag = bus.in_addr[31:IDX_W];

    // Descending scan so the lowest matching/free way wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_has_free = 1'b0;
        w_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_has_free = 1'b1;
                w_free_way = WAY_W'(w);
            end
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // One extra bit keeps |-32768| and |-2^31| representable.
    assign w_grad17   = {bus.in_grad[15], bus.in_grad};
    assign w_grad_mag = w_grad17[16] ? 17'(-w_grad17) : 17'(w_grad17);
    assign w_grad32   = {{16{bus.in_grad[15]}}, bus.in_grad};
    assign w_grad_big = ({15'd0, w_grad_mag} >= THRESHOLD);

    assign w_acc_new  = r_acc[w_idx][w_hit_way] + w_grad32;
    assign w_acc33    = {w_acc_new[31], w_acc_new};
    assign w_acc_mag  = w_acc33[32] ? 33'(-w_acc33) : 33'(w_acc33);
    assign w_acc_big  = (w_acc_mag >= {1'b0, THRESHOLD});
    assign w_cnt_new  = r_cnt[w_idx][w_hit_way] + 1'b1;
    assign w_cnt_max  = (w_cnt_new == CNT_W'(MAX_UPDATES));

    assign w_rr_cur   = r_rr[w_idx];
    assign w_rr_next  = (w_rr_cur == WAY_W'(NUM_WAYS - 1)) ? '0 : w_rr_cur + 1'b1;

    always_comb begin
        w_push       = 1'b0;
        w_push_addr  = bus.in_addr;
        w_push_value = w_grad32;
        w_wr_en      = 1'b0;
        w_wr_way     = w_hit_way;
        w_wr_valid   = 1'b0;
        w_wr_acc     = '0;
        w_wr_cnt     = '0;
        w_rr_inc     = 1'b0;
        w_ev_direct  = 1'b0;
        w_ev_thr     = 1'b0;
        w_ev_max     = 1'b0;
        w_ev_evict   = 1'b0;
        w_ev_hit     = 1'b0;
        w_ev_miss    = 1'b0;
        if (w_accept) begin
            if (w_grad_big) begin
                w_ev_direct = 1'b1;
                w_push      = 1'b1;
                if (w_hit) begin
                    w_push_value = w_acc_new;
                    w_wr_en      = 1'b1;
                end
            end else if (w_hit) begin
                w_ev_hit   = 1'b1;
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b1;
                w_wr_acc   = w_acc_new;
                w_wr_cnt   = w_cnt_new;
                if (w_acc_big || w_cnt_max) begin
                    w_ev_thr     = w_acc_big;
                    w_ev_max     = !w_acc_big;
                    w_push       = 1'b1;
                    w_push_value = w_acc_new;
                    w_wr_valid   = 1'b0;
                    w_wr_acc     = '0;
                    w_wr_cnt     = '0;
                end
            end else begin
                w_ev_miss  = 1'b1;
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b1;
                w_wr_acc   = w_grad32;
                w_wr_cnt   = CNT_W'(1);
                if (w_has_free) begin
                    w_wr_way = w_free_way;
                end else begin
                    w_wr_way     = w_rr_cur;
                    w_rr_inc     = 1'b1;
                    w_ev_evict   = 1'b1;
                    w_push       = 1'b1;
                    w_push_addr  = {r_tag[w_idx][w_rr_cur], w_idx};
                    w_push_value = r_acc[w_idx][w_rr_cur];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_acc[s][w]   <= '0;
                    r_cnt[s][w]   <= '0;
                end
            end
        end else if (w_wr_en) begin
            r_valid[w_idx][w_wr_way] <= w_wr_valid;
            r_tag[w_idx][w_wr_way]   <= w_tag;
            r_acc[w_idx][w_wr_way]   <= w_wr_acc;
            r_cnt[w_idx][w_wr_way]   <= w_wr_cnt;
            if (w_rr_inc) begin
                r_rr[w_idx] <= w_rr_next;
            end
        end
    end

    // FIFO storage; unread slots are masked at the output, so no reset is needed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= w_push_addr;
            r_fifo_val[r_wptr]  <= w_push_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_burst_cnt_next = r_burst_cnt;
        unique case (r_state)
            StIdle: begin
                if (debug_burst_ready ||
                    (!w_empty && (r_idle_cnt >= ICNT_W'(IDLE_FLUSH)))) begin
                    w_state_next     = StBurst;
                    w_burst_cnt_next = '0;
                end
            end
            StBurst: begin
                if (w_pop) begin
                    w_burst_cnt_next = r_burst_cnt + 1'b1;
                end
                if ((w_pop && (r_burst_cnt == BCNT_W'(BURST_SIZE - 1))) || w_empty) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_burst_cnt_next;
            if (bus.in_valid) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt < ICNT_W'(IDLE_FLUSH)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dbg_direct <= 1'b0;
            r_dbg_thr    <= 1'b0;
            r_dbg_max    <= 1'b0;
            r_dbg_evict  <= 1'b0;
            r_dbg_hit    <= 1'b0;
            r_dbg_miss   <= 1'b0;
        end else begin
            r_dbg_direct <= w_ev_direct;
            r_dbg_thr    <= w_ev_thr;
            r_dbg_max    <= w_ev_max;
            r_dbg_evict  <= w_ev_evict;
            r_dbg_hit    <= w_ev_hit;
            r_dbg_miss   <= w_ev_miss;
        end
    end

    assign bus.dram_valid = w_dram_valid;
    assign bus.dram_addr  = w_dram_valid ? r_fifo_addr[r_rptr] : '0;
    assign bus.dram_value = w_dram_valid ? r_fifo_val[r_rptr] : '0;

    assign debug_wb_direct          = r_dbg_direct;
    assign debug_wb_accum_threshold = r_dbg_thr;
    assign debug_wb_max_updates     = r_dbg_max;
    assign debug_wb_eviction        = r_dbg_evict;
    assign debug_hit                = r_dbg_hit;
    assign debug_miss               = r_dbg_miss;
    assign debug_fifo_count         = r_count;
    assign debug_burst_ready        = (r_count >= FCNT_W'(BURST_SIZE));
    assign debug_fifo_full          = w_full;
    assign debug_draining           = (r_state == StBurst);

`ifdef PERF_MON_EN
    logic [31:0] r_perf_raw, r_perf_out;
    logic [63:0] w_raw_bytes, w_out_bytes;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_raw <= '0;
            r_perf_out <= '0;
        end else begin
            if (bus.in_valid && (r_perf_raw != '1)) begin
                r_perf_raw <= r_perf_raw + 1'b1;
            end
            if (w_pop && (r_perf_out != '1)) begin
                r_perf_out <= r_perf_out + 1'b1;
            end
        end
    end

    assign w_raw_bytes    = 64'(r_perf_raw) * 64'(DATA_BYTES);
    assign w_out_bytes    = 64'(r_perf_out) * 64'(DATA_BYTES);
    assign perf_raw_count = r_perf_raw;
    assign perf_out_count = r_perf_out;
    assign perf_raw_bytes = (|w_raw_bytes[63:32]) ? '1 : w_raw_bytes[31:0];
    assign perf_out_bytes = (|w_out_bytes[63:32]) ? '1 : w_out_bytes[31:0];
`else
    logic w_unused_data_bytes;
    assign w_unused_data_bytes = ^DATA_BYTES;
    assign perf_raw_count = '0;
    assign perf_out_count = '0;
    assign perf_raw_bytes = '0;
    assign perf_out_bytes = '0;
`endif

endmodule

// File: tb/tb_gradient_accum_compressor.sv
// Directed bench for gradient_accum_compressor: default instance plus a THRESHOLD=1000 instance.
module tb_gradient_accum_compressor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gradient_accum_compressor_if u_if ();
    gradient_accum_compressor_if u_if2 ();

    logic       d_direct, d_thr, d_max, d_evict, d_hit, d_miss, d_bready, d_full, d_drain;
    logic [5:0] d_count;
    logic [31:0] p_raw, p_out, p_raw_b, p_out_b;
    logic       e_direct, e_thr, e_max, e_evict, e_hit, e_miss, e_bready, e_full, e_drain;
    logic [5:0] e_count;
    logic [31:0] q_raw, q_out, q_raw_b, q_out_b;

    gradient_accum_compressor u_dut (
        .clock(clk), .reset(rst), .bus(u_if),
        .debug_wb_direct(d_direct), .debug_wb_accum_threshold(d_thr),
        .debug_wb_max_updates(d_max), .debug_wb_eviction(d_evict),
        .debug_hit(d_hit), .debug_miss(d_miss), .debug_fifo_count(d_count),
        .debug_burst_ready(d_bready), .debug_fifo_full(d_full), .debug_draining(d_drain),
        .perf_raw_count(p_raw), .perf_out_count(p_out),
        .perf_raw_bytes(p_raw_b), .perf_out_bytes(p_out_b)
    );

    gradient_accum_compressor #(.THRESHOLD(32'd1000)) u_dut_thr (
        .clock(clk), .reset(rst), .bus(u_if2),
        .debug_wb_direct(e_direct), .debug_wb_accum_threshold(e_thr),
        .debug_wb_max_updates(e_max), .debug_wb_eviction(e_evict),
        .debug_hit(e_hit), .debug_miss(e_miss), .debug_fifo_count(e_count),
        .debug_burst_ready(e_bready), .debug_fifo_full(e_full), .debug_draining(e_drain),
        .perf_raw_count(q_raw), .perf_out_count(q_out),
        .perf_raw_bytes(q_raw_b), .perf_out_bytes(q_out_b)
    );

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int n_direct = 0, n_thr = 0, n_max = 0, n_evict = 0, n_hit = 0, n_miss = 0;
    int n_valid_cyc = 0, n_hs = 0, n2_max = 0, n2_miss = 0, n2_thr = 0;
    logic [63:0] cap_q[$];
    logic [63:0] cap2_q[$];

    // Event and handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (d_direct) n_direct++;
            if (d_thr)    n_thr++;
            if (d_max)    n_max++;
            if (d_evict)  n_evict++;
            if (d_hit)    n_hit++;
            if (d_miss)   n_miss++;
            if (e_max)    n2_max++;
            if (e_miss)   n2_miss++;
            if (e_thr)    n2_thr++;
            if (u_if.in_valid) n_valid_cyc++;
            if (u_if.dram_valid && u_if.dram_ready) begin
                cap_q.push_back({u_if.dram_addr, u_if.dram_value});
                n_hs++;
            end
            if (u_if2.dram_valid && u_if2.dram_ready) begin
                cap2_q.push_back({u_if2.dram_addr, u_if2.dram_value});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic signed [15:0] g);
        int budget = 200;
        u_if.in_valid = 1'b1;
        u_if.in_addr  = a;
        u_if.in_grad  = g;
        while (!u_if.in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("send_in_ready_timeout", u_if.in_ready, 1);
        tick();
        u_if.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] a, input logic signed [15:0] g);
        u_if2.in_valid = 1'b1;
        u_if2.in_addr  = a;
        u_if2.in_grad  = g;
        tick();
        u_if2.in_valid = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int budget);
        while (cap_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        chk("drain_count", cap_q.size(), n);
    endtask

    task automatic chk_cap(input string tag, input int i, input logic [31:0] a,
                           input logic [31:0] v);
        chk(tag, (i < cap_q.size()) ? cap_q[i] : '1, {a, v});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_hit, b_miss, b_thr, b_direct, b_evict, k, budget;
        rst = 1'b1;
        u_if.in_valid = 1'b0;  u_if.in_addr = '0;  u_if.in_grad = '0;  u_if.dram_ready = 1'b1;
        u_if2.in_valid = 1'b0; u_if2.in_addr = '0; u_if2.in_grad = '0; u_if2.dram_ready = 1'b1;
        repeat (3) tick();
        chk("rst_fifo_count", d_count, 0);
        chk("rst_dram_valid", u_if.dram_valid, 0);
        chk("rst_draining", d_drain, 0);
        chk("rst_burst_ready", d_bready, 0);
        chk("rst_pulses", {d_direct, d_thr, d_max, d_evict, d_hit, d_miss}, 0);
        chk("rst_perf_raw", p_raw, 0);
        rst = 1'b0;
        tick();
        chk("in_ready_after_reset", u_if.in_ready, 1);

        // Small gradients accumulate silently for 12 rounds; round 13 crosses 50.
        b_hit = n_hit; b_miss = n_miss;
        for (int r = 0; r < 10; r++)
            for (int i = 0; i < 32; i++) send(32'h100 + i, 16'sd4);
        tick();
        chk("t1_hits", n_hit - b_hit, 288);
        chk("t1_misses", n_miss - b_miss, 32);
        chk("t1_fifo_empty", d_count, 0);
        repeat (20) tick();
        chk("t1_no_dram", cap_q.size(), 0);
        b_thr = n_thr;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 32; i++) send(32'h100 + i, 16'sd4);
        wait_caps(32, 500);
        chk("t1_thr_pulses", n_thr - b_thr, 32);
        for (int i = 0; i < 32; i++) chk_cap("t1_wb", i, 32'h100 + i, 32'd52);

        // Outliers bypass; burst held by dram_ready=0.
        cap_q.delete();
        u_if.dram_ready = 1'b0;
        b_direct = n_direct;
        for (int i = 0; i < 16; i++) send(32'h1000 + i, 16'sd100);
        chk("t2_count", d_count, 16);
        chk("t2_burst_ready", d_bready, 1);
        tick();
        chk("t2_draining", d_drain, 1);
        chk("t2_dram_valid", u_if.dram_valid, 1);
        chk("t2_head", {u_if.dram_addr, u_if.dram_value}, {32'h1000, 32'd100});
        tick();
        chk("t2_head_stable", {u_if.dram_addr, u_if.dram_value}, {32'h1000, 32'd100});
        chk("t2_direct_pulses", n_direct - b_direct, 16);
        u_if.dram_ready = 1'b1;
        wait_caps(16, 200);
        for (int i = 0; i < 16; i++) chk_cap("t2_wb", i, 32'h1000 + i, 32'd100);

        // Accumulated threshold, then the invalidated entry must miss.
        cap_q.delete();
        b_thr = n_thr; b_hit = n_hit; b_miss = n_miss; b_direct = n_direct;
        send(32'h300, 16'sd15);
        send(32'h300, 16'sd40);
        tick();
        chk("t3_thr", n_thr - b_thr, 1);
        chk("t3_hit", n_hit - b_hit, 1);
        send(32'h300, 16'sd1);
        tick();
        chk("t3_reinstall_miss", n_miss - b_miss, 2);
        send(32'h300, 16'sd60);
        tick();
        chk("t3_direct_hit", n_direct - b_direct, 1);
        wait_caps(2, 200);
        chk_cap("t3_wb_thr", 0, 32'h300, 32'd55);
        chk_cap("t3_wb_direct", 1, 32'h300, 32'd61);

        // Fill set 0, fifth tag evicts way 0.
        cap_q.delete();
        b_evict = n_evict; b_miss = n_miss; b_thr = n_thr; b_hit = n_hit;
        send(32'h000, 16'sd5);
        send(32'h020, 16'sd5);
        send(32'h040, 16'sd5);
        send(32'h060, 16'sd5);
        send(32'h080, 16'sd8);
        tick();
        chk("t4_evict", n_evict - b_evict, 1);
        chk("t4_miss", n_miss - b_miss, 5);
        send(32'h080, 16'sd42);
        tick();
        chk("t4_resident_thr", n_thr - b_thr, 1);
        chk("t4_resident_hit", n_hit - b_hit, 1);
        wait_caps(2, 200);
        chk_cap("t4_wb_evict", 0, 32'h000, 32'd5);
        chk_cap("t4_wb_thr", 1, 32'h080, 32'd50);

        // Negative magnitudes at the boundary.
        cap_q.delete();
        b_direct = n_direct; b_thr = n_thr;
        send(32'h400, -16'sd32768);
        send(32'h500, -16'sd49);
        send(32'h500, -16'sd1);
        send(32'h600, 16'sd49);
        send(32'h601, -16'sd50);
        tick();
        chk("t5_direct", n_direct - b_direct, 2);
        chk("t5_thr", n_thr - b_thr, 1);
        wait_caps(3, 200);
        chk_cap("t5_min_grad", 0, 32'h400, 32'hFFFF_8000);
        chk_cap("t5_neg_acc", 1, 32'h500, 32'hFFFF_FFCE);
        chk_cap("t5_neg_direct", 2, 32'h601, 32'hFFFF_FFCE);
        repeat (3) tick();
        chk("t5_no_extra", cap_q.size(), 3);

        // Backpressure: FIFO fills at 32 and holds off the rest.
        cap_q.delete();
        u_if.dram_ready = 1'b0;
        k = 0;
        u_if.in_valid = 1'b1;
        for (int c = 0; c < 36; c++) begin
            u_if.in_addr = 32'h2000 + k;
            u_if.in_grad = 16'sd100;
            if (u_if.in_ready) k++;
            tick();
        end
        chk("t6_accepted", k, 32);
        chk("t6_in_ready_low", u_if.in_ready, 0);
        chk("t6_full", d_full, 1);
        chk("t6_count", d_count, 32);
        u_if.dram_ready = 1'b1;
        budget = 200;
        while (k < 40 && budget > 0) begin
            u_if.in_addr = 32'h2000 + k;
            u_if.in_grad = 16'sd100;
            if (u_if.in_ready) k++;
            tick();
            budget--;
        end
        u_if.in_valid = 1'b0;
        chk("t6_all_accepted", k, 40);
        wait_caps(40, 500);
        for (int i = 0; i < 40; i++) chk_cap("t6_wb", i, 32'h2000 + i, 32'd100);
        tick();
`ifdef PERF_MON_EN
        chk("perf_raw", p_raw, n_valid_cyc);
        chk("perf_out", p_out, n_hs);
        chk("perf_raw_bytes", p_raw_b, n_valid_cyc * 4);
        chk("perf_out_bytes", p_out_b, n_hs * 4);
`else
        chk("perf_raw_off", p_raw, 0);
        chk("perf_out_off", p_out, 0);
        chk("perf_bytes_off", {p_raw_b, p_out_b}, 0);
`endif

        // Update cap on the THRESHOLD=1000 instance.
        for (int i = 0; i < 255; i++) send2(32'hA00, 16'sd1);
        tick();
        chk("t7_max_updates", n2_max, 1);
        chk("t7_first_miss", n2_miss, 1);
        send2(32'hA00, 16'sd1);
        tick();
        chk("t7_reinstall_miss", n2_miss, 2);
        send2(32'hA00, 16'sd999);
        tick();
        chk("t7_thr", n2_thr, 1);
        budget = 200;
        while (cap2_q.size() < 2 && budget > 0) begin
            tick();
            budget--;
        end
        chk("t7_drain_count", cap2_q.size(), 2);
        chk("t7_wb_max", (cap2_q.size() > 0) ? cap2_q[0] : '1, {32'hA00, 32'd255});
        chk("t7_wb_thr", (cap2_q.size() > 1) ? cap2_q[1] : '1, {32'hA00, 32'd1000});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
